// File: rtl/vx_gbar_unit_pkg.sv
// Shared definitions for the cluster global-barrier responder: default geometry,
// derived id/size widths, perf counter width and the selected-request record.
package vx_gbar_unit_pkg;

   // Bit width needed to encode n distinct values, never less than one.
   function automatic int unsigned width_of(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

   localparam int unsigned GBAR_NUM_CORES    = 4;
   localparam int unsigned GBAR_NUM_BARRIERS = 8;
   localparam int unsigned NB_WIDTH          = width_of(GBAR_NUM_BARRIERS);
   localparam int unsigned NC_WIDTH          = width_of(GBAR_NUM_CORES);
   localparam int unsigned PERF_CTR_BITS     = 32;

   typedef struct packed {
      logic [NB_WIDTH-1:0] id;
      logic [NC_WIDTH-1:0] size_m1;
      logic [NC_WIDTH-1:0] core_id;
   } gbar_req_t;

endpackage

// File: rtl/vx_gbar_unit_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant and index, pointer moves
// to one past the granted requester.
module vx_gbar_unit_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  valid_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_any_o
);

   logic [IW-1:0] ptr_q, ptr_d;

   // First pass covers indices at or above the pointer, second pass wraps to the bottom.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_any_o && valid_i[i] && (IW'(i) >= ptr_q)) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = IW'(i);
            grant_any_o = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!grant_any_o && valid_i[i]) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = IW'(i);
            grant_any_o = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_any_o) begin
         ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/vx_gbar_unit.sv
// Cluster global-barrier responder: accepts one core arrival per cycle, tracks
// per-barrier arrival masks and broadcasts a one-cycle release. GBAR_PERF_EN adds perf counters.
module vx_gbar_unit
   import vx_gbar_unit_pkg::*;
#(
   parameter int unsigned NUM_CORES    = GBAR_NUM_CORES,
   parameter int unsigned NUM_BARRIERS = GBAR_NUM_BARRIERS,
   parameter int unsigned NBW          = width_of(NUM_BARRIERS),
   parameter int unsigned NCW          = width_of(NUM_CORES)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CORES-1:0]     req_valid,
   input  logic [NUM_CORES*NBW-1:0] req_id,
   input  logic [NUM_CORES*NCW-1:0] req_size_m1,
   input  logic [NUM_CORES*NCW-1:0] req_core_id,
   output logic [NUM_CORES-1:0]     req_ready,
   output logic                     rsp_valid,
   output logic [NBW-1:0]           rsp_id,
   output logic                     dup_err,
   output logic                     busy
`ifdef GBAR_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0] perf_releases,
   output logic [PERF_CTR_BITS-1:0] perf_wait_cycles,
   output logic [PERF_CTR_BITS-1:0] perf_conflicts
`endif
);

   logic [NUM_CORES-1:0] gnt;
   logic [NCW-1:0]       gnt_idx;
   logic                 gnt_any;
   logic                 accept;
   gbar_req_t            req;

   logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
   logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
   logic [NUM_CORES-1:0] cur_mask;
   logic [NUM_CORES-1:0] core_oh;
   logic [NCW:0]         cnt;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [NBW-1:0]       rsp_id_q, rsp_id_d;
   logic                 dup_err_q, dup_err_d;

   vx_gbar_unit_rr_arbiter #(
      .N  (NUM_CORES),
      .IW (NCW)
   ) u_arb (
      .clk_i       (clk),
      .rst_ni      (reset),
      .valid_i     (req_valid),
      .grant_o     (gnt),
      .grant_idx_o (gnt_idx),
      .grant_any_o (gnt_any)
   );

   assign req_ready = reset ? gnt : '0;
   assign accept    = reset & gnt_any;

   always_comb begin
      req         = '0;
      req.id      = req_id[gnt_idx*NBW +: NBW];
      req.size_m1 = req_size_m1[gnt_idx*NCW +: NCW];
      req.core_id = req_core_id[gnt_idx*NCW +: NCW];
   end

   // Out-of-range core ids decode to an all-zero one-hot and so touch nothing.
   always_comb begin
      core_oh = '0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         core_oh[c] = (req.core_id == NCW'(c));
      end
   end

   always_comb begin
      cur_mask = '0;
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
         if (req.id == NBW'(b)) cur_mask = mask_q[b];
      end
      cnt = '0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         cnt = cnt + (NCW+1)'(cur_mask[c]);
      end
   end

   always_comb begin
      mask_d      = mask_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      dup_err_d   = dup_err_q;
      if (accept && (|core_oh)) begin
         if (|(cur_mask & core_oh)) begin
            dup_err_d = 1'b1;
         end else if (cnt == {1'b0, req.size_m1}) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = req.id;
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
               if (req.id == NBW'(b)) mask_d[b] = '0;
            end
         end else begin
            for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
               if (req.id == NBW'(b)) mask_d[b] = mask_q[b] | core_oh;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned b = 0; b < NUM_BARRIERS; b++) mask_q[b] <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         dup_err_q   <= 1'b0;
      end else begin
         mask_q      <= mask_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         dup_err_q   <= dup_err_d;
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) busy = busy | (|mask_q[b]);
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign dup_err   = dup_err_q;

`ifdef GBAR_PERF_EN
   logic [PERF_CTR_BITS-1:0] rel_ctr_q, wait_ctr_q, conf_ctr_q;
   logic                     multi_req;

   // Clearing the lowest set bit leaves something only when two or more requests are valid.
   assign multi_req = |(req_valid & (req_valid - NUM_CORES'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rel_ctr_q  <= '0;
         wait_ctr_q <= '0;
         conf_ctr_q <= '0;
      end else begin
         if (rsp_valid_q) rel_ctr_q  <= rel_ctr_q + PERF_CTR_BITS'(1);
         if (busy)        wait_ctr_q <= wait_ctr_q + PERF_CTR_BITS'(1);
         if (multi_req)   conf_ctr_q <= conf_ctr_q + PERF_CTR_BITS'(1);
      end
   end

   assign perf_releases    = rel_ctr_q;
   assign perf_wait_cycles = wait_ctr_q;
   assign perf_conflicts   = conf_ctr_q;
`endif

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Bench for vx_gbar_unit (4 cores, 8 barriers): vector table, reset sequence and
// randomized traffic against a behavioural barrier model.
module tb_vx_gbar_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [11:0] req_id;
   logic [7:0]  req_size_m1;
   logic [7:0]  req_core_id;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [2:0]  rsp_id;
   logic        dup_err;
   logic        busy;
`ifdef GBAR_PERF_EN
   logic [31:0] perf_releases, perf_wait_cycles, perf_conflicts;
`endif

   vx_gbar_unit #(
      .NUM_CORES    (4),
      .NUM_BARRIERS (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_id      (req_id),
      .req_size_m1 (req_size_m1),
      .req_core_id (req_core_id),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .dup_err     (dup_err),
      .busy        (busy)
`ifdef GBAR_PERF_EN
      ,
      .perf_releases    (perf_releases),
      .perf_wait_cycles (perf_wait_cycles),
      .perf_conflicts   (perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [11:0] id;
      logic [1:0]  sz;
      logic [7:0]  cid;
      logic [3:0]  rdy;
      logic        rv;
      logic [2:0]  rid;
      logic        busy;
      logic        dup;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] ids(input int a, input int b, input int c, input int d);
      return {3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   // Each core reports its own index as core id; size is the same on all lanes.
   function automatic vec_t mk(input logic [3:0] v, input logic [11:0] id, input int sz,
                               input logic [3:0] rdy, input bit rv, input int rid,
                               input bit bsy, input bit dup);
      vec_t e;
      e.v = v; e.id = id; e.sz = 2'(sz); e.cid = 8'b11_10_01_00;
      e.rdy = rdy; e.rv = rv; e.rid = 3'(rid); e.busy = bsy; e.dup = dup;
      return e;
   endfunction

   // Called at posedge+1: drive, sample at the falling edge, then advance one cycle.
   task automatic apply(input vec_t e, input string tag);
      req_valid   = e.v;
      req_id      = e.id;
      req_size_m1 = {4{e.sz}};
      req_core_id = e.cid;
      #4;
      chk({tag, ".ready"}, 32'(req_ready), 32'(e.rdy));
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e.rv));
      if (e.rv) chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(e.rid));
      chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
      chk({tag, ".dup_err"}, 32'(dup_err), 32'(e.dup));
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: arrival sets per barrier, rotating priority start.
   bit         arr [8][4];
   int         mptr;
   bit         m_rv;
   int         m_rid;
   bit         m_dup;

   initial begin
      logic [11:0] I0, I1, I3, I4, I6;
      logic [3:0]  v;
      logic [11:0] rid_v;
      logic [7:0]  rsz_v, rcid_v;
      int          g, b, s, k, cnt, c;
      bit          any;

      I0 = ids(0,0,0,0); I1 = ids(1,1,1,1); I3 = ids(3,3,3,3);
      I4 = ids(4,4,4,4); I6 = ids(6,6,6,6);

      // staggered arrivals on id 3, full group of four
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(4'h1, I3, 3, 4'h1, 0, 0, 0, 0));
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(4'h2, I3, 3, 4'h2, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(4'h4, I3, 3, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(4'h8, I3, 3, 4'h8, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 1, 3, 0, 0));
      tbl.push_back(mk(4'h0, I3, 3, 4'h0, 0, 0, 0, 0));
      // all four contend on id 1; each drops its request once granted
      tbl.push_back(mk(4'hF, I1, 3, 4'h1, 0, 0, 0, 0));
      tbl.push_back(mk(4'hE, I1, 3, 4'h2, 0, 0, 1, 0));
      tbl.push_back(mk(4'hC, I1, 3, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(4'h8, I1, 3, 4'h8, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I1, 3, 4'h0, 1, 1, 0, 0));
      tbl.push_back(mk(4'h0, I1, 3, 4'h0, 0, 0, 0, 0));
      // interleaved ids 2 and 5, pairs of cores 0 and 1
      tbl.push_back(mk(4'h1, ids(2,0,0,0), 1, 4'h1, 0, 0, 0, 0));
      tbl.push_back(mk(4'h1, ids(5,0,0,0), 1, 4'h1, 0, 0, 1, 0));
      tbl.push_back(mk(4'h2, ids(0,2,0,0), 1, 4'h2, 0, 0, 1, 0));
      tbl.push_back(mk(4'h2, ids(0,5,0,0), 1, 4'h2, 1, 2, 1, 0));
      tbl.push_back(mk(4'h0, I0, 1, 4'h0, 1, 5, 0, 0));
      tbl.push_back(mk(4'h0, I0, 1, 4'h0, 0, 0, 0, 0));
      // id 4 re-armed in its own release cycle
      tbl.push_back(mk(4'h1, I4, 1, 4'h1, 0, 0, 0, 0));
      tbl.push_back(mk(4'h2, I4, 1, 4'h2, 0, 0, 1, 0));
      tbl.push_back(mk(4'h1, I4, 1, 4'h1, 1, 4, 0, 0));
      tbl.push_back(mk(4'h0, I4, 1, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(4'h2, I4, 1, 4'h2, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I4, 1, 4'h0, 1, 4, 0, 0));
      tbl.push_back(mk(4'h0, I4, 1, 4'h0, 0, 0, 0, 0));
      // core 2 arrives twice at id 0; error is sticky, barrier still completes
      tbl.push_back(mk(4'h4, I0, 3, 4'h4, 0, 0, 0, 0));
      tbl.push_back(mk(4'h4, I0, 3, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(4'h0, I0, 3, 4'h0, 0, 0, 1, 1));
      tbl.push_back(mk(4'h1, I0, 3, 4'h1, 0, 0, 1, 1));
      tbl.push_back(mk(4'h2, I0, 3, 4'h2, 0, 0, 1, 1));
      tbl.push_back(mk(4'h8, I0, 3, 4'h8, 0, 0, 1, 1));
      tbl.push_back(mk(4'h0, I0, 3, 4'h0, 1, 0, 0, 1));
      tbl.push_back(mk(4'h0, I0, 3, 4'h0, 0, 0, 0, 1));

      reset = 1'b0;
      req_valid = 4'hF; req_id = '0; req_size_m1 = '0; req_core_id = '0;
      #1;
      chk("reset.ready", 32'(req_ready), 32'h0);
      chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset.rsp_id", 32'(rsp_id), 32'h0);
      chk("reset.dup_err", 32'(dup_err), 32'h0);
      chk("reset.busy", 32'(busy), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = 4'h0;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // two of four arrivals pending on id 6 when reset hits
      apply(mk(4'h1, I6, 3, 4'h1, 0, 0, 0, 1), "rst_pre0");
      apply(mk(4'h2, I6, 3, 4'h2, 0, 0, 1, 1), "rst_pre1");
      reset = 1'b0;
      req_valid = 4'hF;
      #1;
      chk("rst_mid.ready", 32'(req_ready), 32'h0);
      chk("rst_mid.busy", 32'(busy), 32'h0);
      chk("rst_mid.dup_err", 32'(dup_err), 32'h0);
      chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold.rsp_valid", 32'(rsp_valid), 32'h0);
      reset = 1'b1;
      apply(mk(4'h0, I6, 3, 4'h0, 0, 0, 0, 0), "rst_post0");
      apply(mk(4'h1, I6, 3, 4'h1, 0, 0, 0, 0), "rst_post1");
      apply(mk(4'h2, I6, 3, 4'h2, 0, 0, 1, 0), "rst_post2");
      apply(mk(4'h4, I6, 3, 4'h4, 0, 0, 1, 0), "rst_post3");
      apply(mk(4'h8, I6, 3, 4'h8, 0, 0, 1, 0), "rst_post4");
      apply(mk(4'h0, I6, 3, 4'h0, 1, 6, 0, 0), "rst_post5");
      apply(mk(4'h0, I6, 3, 4'h0, 0, 0, 0, 0), "rst_post6");

      // fresh start for the randomized phase so the model begins empty
      reset = 1'b0;
      req_valid = 4'h0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      foreach (arr[i, j]) arr[i][j] = 1'b0;
      mptr = 0; m_rv = 1'b0; m_rid = 0; m_dup = 1'b0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         v = 4'($urandom_range(0, 15));
         for (int q = 0; q < 4; q++) begin
            b = $urandom_range(0, 2);
            rid_v[q*3 +: 3] = 3'(b);
            s = (b == 0) ? 0 : (b == 1) ? 1 : 3;
            if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 3);
            rsz_v[q*2 +: 2] = 2'(s);
            k = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : q;
            rcid_v[q*2 +: 2] = 2'(k);
         end
         g = -1;
         for (int q = 0; q < 4; q++) begin
            c = (mptr + q) % 4;
            if (g < 0 && v[c]) g = c;
         end
         req_valid = v; req_id = rid_v; req_size_m1 = rsz_v; req_core_id = rcid_v;
         #4;
         any = 1'b0;
         foreach (arr[i, j]) any = any | arr[i][j];
         chk("rnd.ready", 32'(req_ready), (g < 0) ? 32'h0 : (32'h1 << g));
         chk("rnd.rsp_valid", 32'(rsp_valid), 32'(m_rv));
         if (m_rv) chk("rnd.rsp_id", 32'(rsp_id), 32'(m_rid));
         chk("rnd.dup_err", 32'(dup_err), 32'(m_dup));
         chk("rnd.busy", 32'(busy), 32'(any));
         m_rv = 1'b0;
         if (g >= 0) begin
            b = int'(rid_v[g*3 +: 3]);
            s = int'(rsz_v[g*2 +: 2]);
            k = int'(rcid_v[g*2 +: 2]);
            cnt = 0;
            for (int q = 0; q < 4; q++) cnt += int'(arr[b][q]);
            if (arr[b][k]) begin
               m_dup = 1'b1;
            end else if (cnt == s) begin
               for (int q = 0; q < 4; q++) arr[b][q] = 1'b0;
               m_rv = 1'b1;
               m_rid = b;
            end else begin
               arr[b][k] = 1'b1;
            end
            mptr = (g + 1) % 4;
         end
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
